inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction-fetch stage feeding the 128x9 instruction memory and the downstream decode stage.
- Owns the program counter and presents the memory address every cycle.
- Captures the memory's registered read data, tags it with its PC, and hands it to decode over a valid/ready handshake through a 2-entry buffer.
- Also provides a program-load path that drives the memory write port while the core is idle.

Parameters:
- START_ADDR, 7'd0, PC value loaded on reset and on start.
- HALT_WORD, 9'h1FF, instruction encoding that stops fetching.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_addr  out  7  memory address (combinational from state/PC/load inputs)
- mem_we  out  1  memory write enable
- mem_wdata  out  9  memory write data
- mem_rdata  in  9  memory read data, valid the cycle after a read address is presented with mem_we=0
- load_valid  in  1  program-load request
- load_addr  in  7  load address
- load_data  in  9  load data
- start  in  1  begin fetching from START_ADDR
- branch_valid  in  1  redirect request from decode/execute
- branch_target  in  7  redirect address
- out_valid  out  1  instruction available
- out_ready  in  1  decode accepts
- out_instr  out  9  instruction word
- out_pc  out  7  address of out_instr
- halted  out  1  HALT_WORD fetched, fetch stopped

Behaviour:
- States: IDLE, RUN, HALTED. Reset → IDLE.
- Reset values: pc=START_ADDR, buffer empty, in-flight flag 0, out_valid=0, out_instr=0, out_pc=0, halted=0, mem_we=0.
- IDLE, load_valid=1: mem_we=1, mem_addr=load_addr, mem_wdata=load_data in the same cycle.
- IDLE, load_valid=0 and start=1: next state RUN, pc=START_ADDR.
- IDLE, load_valid and start both high: load is performed, start is ignored.
- IDLE, otherwise: mem_we=0, mem_addr=pc, mem_wdata=0.
- load_valid is ignored outside IDLE; mem_we=0 in RUN and HALTED.
- RUN issue rule: issue when no branch_valid and (count + inflight < 2 or a pop occurs this cycle).
  - count = buffer entries; pop = out_valid & out_ready.
  - Issue: mem_addr=pc; at the clock edge pc ← pc+1 (127 wraps to 0), inflight ← 1, tag ← pc.
  - No issue: inflight ← 0.
- Response: in the cycle after an issue, mem_rdata is pushed with its tag into the buffer unless discarded. The push is visible as out_valid the following cycle.
- Latency: first issue cycle N → out_valid at N+2. Sustained throughput is 1 instruction/cycle with out_ready held high.
- Buffer: 2-entry FIFO. out_valid = count≠0; out_instr/out_pc come from the head.
  - Head is held stable while out_valid & !out_ready.
  - The issue rule guarantees no overflow.
- Branch (RUN only): pc ← branch_target; buffer flushed; the response arriving this cycle is discarded; no issue this cycle.
  - A handshake with out_ready high in the same cycle counts as transferred.
  - First instruction from the target appears 3 cycles after the branch cycle.
- Halt: when a pushed word equals HALT_WORD, it is pushed normally. Then: state → HALTED, halted=1, issuing stops, and the next response is discarded.
  - Buffered entries still drain to decode.
- HALTED: branch ignored. start → RUN with pc=START_ADDR, buffer flushed, halted ← 0.
- start in RUN is ignored.
- Reset mid-operation: all state returns to reset values at the next edge. In-flight data is dropped.

Test Plan:
- Reset, then load_valid with addr 0..3 and data 9'h011, 9'h022, 9'h033, 9'h1FF → mem_we=1 with matching addr/data each cycle; out_valid stays 0.
- Start with out_ready=1 after that load → out_valid 2 cycles after the first issue; pc/instr sequence (0,011), (1,022), (2,033), (3,1FF) on consecutive cycles; halted=1 afterwards; no further out_valid.
- Hold out_ready=0 for 5 cycles mid-stream → the buffer fills to 2, then issuing stops; the head stays (1,022). Release → in-order delivery with no loss or duplication.
- branch_valid with target 7'd40 while 2 entries are buffered → entries flushed; next out_pc=40 exactly 3 cycles later; stale pc 2 is never delivered.
- Memory all non-halt, run continuously from pc 126 → out_pc 126, 127, 0, 1 (wrap).
- Assert reset during RUN with entries buffered → next cycle out_valid=0, halted=0, state IDLE, mem_addr=START_ADDR.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives the 128x9 instruction memory and
// hands tagged instructions to decode through a 2-entry buffer.
module inst_fetch_unit #(
  parameter logic [6:0] START_ADDR = 7'd0,
  parameter logic [8:0] HALT_WORD  = 9'h1FF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] mem_addr,
  output logic       mem_we,
  output logic [8:0] mem_wdata,
  input  logic [8:0] mem_rdata,
  input  logic       load_valid,
  input  logic [6:0] load_addr,
  input  logic [8:0] load_data,
  input  logic       start,
  input  logic       branch_valid,
  input  logic [6:0] branch_target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_instr,
  output logic [6:0] out_pc,
  output logic       halted
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [6:0] pc;
    logic [8:0] instr;
  } fetch_t;

  state_t     state;
  logic [6:0] pc;
  logic [6:0] tag;
  logic       inflight;
  fetch_t     fifo [2];
  logic       head;
  logic [1:0] count;

  logic       pop;
  logic       push;
  logic       issue;
  logic       flush;
  logic       halt_hit;
  logic [1:0] occ;

  always_comb begin
    out_valid = (count != 2'd0);
    pop       = out_valid & out_ready;
    occ       = count + {1'b0, inflight};
    issue     = (state == RUN) && !branch_valid &&
                ((occ < 2'd2) || pop);
    // responses are only kept while running and not redirected
    push      = (state == RUN) && inflight && !branch_valid;
    halt_hit  = push && (mem_rdata == HALT_WORD);
    flush     = ((state == RUN) && branch_valid) ||
                ((state == HALTED) && start);
  end

  always_comb begin
    mem_we    = (state == IDLE) && load_valid;
    mem_addr  = mem_we ? load_addr : pc;
    mem_wdata = mem_we ? load_data : 9'd0;
    out_instr = out_valid ? fifo[head].instr : 9'd0;
    out_pc    = out_valid ? fifo[head].pc : 7'd0;
    halted    = (state == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= START_ADDR;
      tag      <= 7'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag <= pc;
        pc  <= pc + 7'd1;
      end
      unique case (state)
        IDLE: begin
          if (!load_valid && start) begin
            state <= RUN;
            pc    <= START_ADDR;
          end
        end
        RUN: begin
          if (branch_valid) pc <= branch_target;
          else if (halt_hit) state <= HALTED;
        end
        HALTED: begin
          if (start) begin
            state <= RUN;
            pc    <= START_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush) begin
        count <= 2'd0;
        head  <= 1'b0;
      end else begin
        // push never meets a full buffer: issue rule bounds occupancy
        if (push) fifo[head ^ count[0]] <= '{pc: tag, instr: mem_rdata};
        count <= count + {1'b0, push} - {1'b0, pop};
        head  <= head ^ pop;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized
// streams checked against an expected-PC scoreboard.
module tb_inst_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] mem_addr;
  logic       mem_we;
  logic [8:0] mem_wdata;
  logic [8:0] mem_rdata;
  logic       load_valid;
  logic [6:0] load_addr;
  logic [8:0] load_data;
  logic       start;
  logic       branch_valid;
  logic [6:0] branch_target;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_instr;
  logic [6:0] out_pc;
  logic       halted;

  int checks = 0;
  int failures = 0;

  logic [8:0] mem [128];
  logic [8:0] img [128];
  logic [8:0] d4 [4];
  logic [6:0] exp_pc;
  logic [6:0] wp;
  int         xfers;
  int         brk_age;
  int         h;
  bit         done;

  always #5 clk = ~clk;

  // registered-read instruction memory
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  inst_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .load_valid(load_valid),
    .load_addr(load_addr),
    .load_data(load_data),
    .start(start),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] p);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, 32'(out_pc), 32'(p));
    chk({tag, "_instr"}, 32'(out_instr), 32'(img[p]));
  endtask

  // writes img[] into memory; returns at a negedge with load_valid low
  task automatic load_all();
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 7'(i);
      load_data  = img[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic fill_img();
    for (int i = 0; i < 128; i++) img[i] = 9'($urandom_range(0, 510));
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_addr = '0;
    load_data = '0;
    start = 1'b0;
    branch_valid = 1'b0;
    branch_target = '0;
    out_ready = 1'b0;
    d4[0] = 9'h011;
    d4[1] = 9'h022;
    d4[2] = 9'h033;
    d4[3] = 9'h1FF;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    reset = 1'b0;

    // program load; start on the last load cycle must be ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 7'(i);
      load_data  = d4[i];
      start      = (i == 3);
      img[i]     = d4[i];
      #1;
      chk("load_we", 32'(mem_we), 32'd1);
      chk("load_addr", 32'(mem_addr), 32'(i));
      chk("load_wdata", 32'(mem_wdata), 32'(d4[i]));
      chk("load_valid_low", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    load_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("start_ignored", 32'(out_valid), 32'd0);

    // run to halt
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("first_issue_addr", 32'(mem_addr), 32'd0);
    chk("lat_n0", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("lat_n1", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk_out("halt_seq", 7'(k));
      chk("halt_flag_seq", 32'(halted), 32'(k == 3));
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_halt_valid", 32'(out_valid), 32'd0);
      chk("post_halt_flag", 32'(halted), 32'd1);
    end

    // fresh image, backpressure then branch then wrap
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fill_img();
    img[0] = 9'h011;
    img[1] = 9'h022;
    img[2] = 9'h033;
    load_all();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_out("bp_n2", 7'd0);
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk_out("bp_head", 7'd1);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk_out("bp_hold", 7'd1);
      chk("bp_no_issue_addr", 32'(mem_addr), 32'd3);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk_out("bp_release", 7'd1);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      #1 chk_out("bp_drain", 7'(k));
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk_out("br_pre", 7'd5);
    @(negedge clk);
    branch_valid = 1'b1;
    branch_target = 7'd40;
    #1 chk_out("br_cycle", 7'd5);
    @(negedge clk);
    branch_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("br_flush1", 32'(out_valid), 32'd0);
    chk("br_target_addr", 32'(mem_addr), 32'd40);
    @(negedge clk);
    #1 chk("br_flush2", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk_out("br_first", 7'd40);
    @(negedge clk);
    #1 chk_out("br_second", 7'd41);
    @(negedge clk);
    branch_valid = 1'b1;
    branch_target = 7'd126;
    @(negedge clk);
    branch_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wp = 7'(126 + k);
      #1 chk_out("wrap", wp);
    end

    // reset with two buffered entries
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mid_rst_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_idle_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_idle_addr", 32'(mem_addr), 32'd0);

    // random stream with branches and backpressure
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_pc = 7'd0;
    xfers = 0;
    brk_age = 100;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      branch_valid = ($urandom_range(0, 15) == 0);
      branch_target = 7'($urandom);
      brk_age++;
      #1;
      if (brk_age == 1 || brk_age == 2)
        chk("rand_br_gap", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        chk("rand_pc", 32'(out_pc), 32'(exp_pc));
        chk("rand_instr", 32'(out_instr), 32'(img[exp_pc]));
        exp_pc = exp_pc + 7'd1;
        xfers++;
      end
      if (branch_valid) begin
        exp_pc = branch_target;
        brk_age = 0;
      end
    end
    branch_valid = 1'b0;
    chk("rand_xfers_enough", 32'(xfers > 400), 32'd1);

    // random stream ending in a halt word
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fill_img();
    h = $urandom_range(5, 60);
    img[h] = 9'h1FF;
    load_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_pc = 7'd0;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("hrand_pc", 32'(out_pc), 32'(exp_pc));
        chk("hrand_instr", 32'(out_instr), 32'(img[exp_pc]));
        if (32'(exp_pc) == h) done = 1'b1;
        exp_pc = exp_pc + 7'd1;
      end
    end
    chk("hrand_reached", 32'(done), 32'd1);
    repeat (8) begin
      @(negedge clk);
      #1;
      chk("hrand_quiet", 32'(out_valid), 32'd0);
      chk("hrand_halted", 32'(halted), 32'd1);
    end

    // restart from HALTED
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    branch_valid = 1'b0;
    #1 chk("restart_pre_halted", 32'(halted), 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1 chk("restart_halted_clr", 32'(halted), 32'd0);
    @(negedge clk);
    #1 chk("restart_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk_out("restart_first", 7'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
